alu_pipe: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Sits between the decode/operand-fetch stage and writeback.
- Accepts one operation per valid/ready handshake and returns a registered result with status flags.
- Adds width generalisation, signed compare, true arithmetic shift, full flag set, back-pressure and an optional iterative multiplier.

---
 rtl/alu_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake on both sides and a full status-flag set.
// Define ALU_PIPE_MUL_EN to build opcode 0011 as a WIDTH-cycle shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTS = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0011;
`endif

  logic             accept;
  logic             out_load;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;
  logic [WIDTH-1:0] load_res;
  logic             load_carry;
  logic             load_ovf;
  logic             load_err;
  logic [TAG_W-1:0] load_tag;

  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, op1} + {1'b0, op2};
  // Top bit of the extended difference is the unsigned borrow (op1 < op2).
  assign diff_ext = {1'b0, op1} - {1'b0, op2};
  assign shamt    = op2[SHAMT_W-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (alu_op)
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               start_mul;
  logic               mul_done;
  logic [SHAMT_W-1:0] mul_cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [TAG_W-1:0]   mul_tag;

  assign start_mul = accept && (alu_op == OP_MUL);
  assign mul_done  = (state_q == S_MUL) && (mul_cnt == SHAMT_W'(WIDTH - 1));
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign out_load  = (accept && !start_mul) || mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state_q == S_IDLE) && (!out_valid || out_ready);
  end

  // The multiplicand shifts left and the multiplier right; one partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset along with the counter so no X can leak into a result.
    if (!rst_n) begin
      mul_cnt <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_tag <= '0;
    end else if (start_mul) begin
      mul_cnt <= '0;
      mcand   <= op1;
      mplier  <= op2;
      acc     <= '0;
      mul_tag <= in_tag;
    end else if (state_q == S_MUL) begin
      mul_cnt <= mul_cnt + 1'b1;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= acc_next;
    end
  end

  always_comb begin
    load_res   = alu_res;
    load_carry = alu_carry;
    load_ovf   = alu_ovf;
    load_err   = alu_err;
    load_tag   = in_tag;
    if (state_q == S_MUL) begin
      load_res   = acc_next;
      load_carry = 1'b0;
      load_ovf   = 1'b0;
      load_err   = 1'b0;
      load_tag   = mul_tag;
    end
  end
`else
  assign out_load = accept;

  always_comb begin
    in_ready = rst_n && (!out_valid || out_ready);
  end

  always_comb begin
    load_res   = alu_res;
    load_carry = alu_carry;
    load_ovf   = alu_ovf;
    load_err   = alu_err;
    load_tag   = in_tag;
  end
`endif

  // A new result may overwrite the slot on the same edge the old one is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      out_tag   <= load_tag;
      zero      <= (load_res == '0);
      neg       <= load_res[WIDTH-1];
      carry     <= load_carry;
      ovf       <= load_ovf;
      err       <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed vectors, back-pressure,
// randomized traffic against an arithmetic reference model, and reset mid-operation.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [3:0]    alu_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [TW-1:0] out_tag;
  logic          zero;
  logic          neg;
  logic          carry;
  logic          ovf;
  logic          err;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          z;
    logic          n;
    logic          c;
    logic          v;
    logic          e;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag);
    exp_t x;
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned s;
    longint sr;
    int sh = int'(b[4:0]);
    x = '0;
    x.tag = tag;
    case (op)
      4'b0000: x.r = a & b;
      4'b0001: x.r = a | b;
      4'b0101: x.r = a ^ b;
      4'b0010: begin
        s = ua + ub; x.r = s[31:0]; x.c = s[32];
        sr = sa + sb; x.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0110: begin
        s = ua - ub; x.r = s[31:0]; x.c = (ua < ub);
        sr = sa - sb; x.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0100: x.r = (ua < ub) ? 32'd1 : 32'd0;
      4'b0111: x.r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: x.r = a >> sh;
      4'b1001: x.r = a << sh;
      4'b1010: x.r = $unsigned($signed(a) >>> sh);
      4'b0011: begin
        if (MUL_EN) begin s = ua * ub; x.r = s[31:0]; end
        else x.e = 1'b1;
      end
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 0);
    x.n = x.r[W-1];
    return x;
  endfunction

  function automatic exp_t observed();
    return {result, out_tag, zero, neg, carry, ovf, err};
  endfunction

  // Offers one op with out_ready=1, then waits (bounded) for its result; lat=-1 on timeout.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output exp_t obs, output int lat, output bit ready_leak);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; op1 = a; op2 = b; in_tag = tag; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) begin @(negedge clk); #1; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; ready_leak = 1'b0; obs = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin obs = observed(); break; end
      if (in_ready) ready_leak = 1'b1;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; alu_op = '0; in_tag = '0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hs: in_ready/out_valid=%b want 00", {in_ready, out_valid});
    end
    n_cmp++;
    if (observed() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_regs: got %h want 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  vec_t dir_tab[14] = '{
    '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000},
    '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000},
    '{4'b0110, 32'h00000001, 32'h00000002, 32'hFFFFFFFF},
    '{4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    '{4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000},
    '{4'b1000, 32'h80000000, 32'h00000024, 32'h08000000},
    '{4'b1001, 32'h00000001, 32'h00000021, 32'h00000002},
    '{4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F},
    '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F},
    '{4'b0101, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555},
    '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{4'b1011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000},
    '{4'b0011, 32'h00010003, 32'h00000007, MUL_EN ? 32'h00070015 : 32'h00000000}
  };

  task automatic test_directed();
    exp_t obs, exp_v;
    int lat, want_lat;
    bit leak;
    logic [TW-1:0] tag;
    foreach (dir_tab[i]) begin
      tag = TW'($urandom);
      issue(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, tag, obs, lat, leak);
      exp_v = model(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, tag);
      want_lat = (dir_tab[i].op == 4'b0011 && MUL_EN) ? W : 1;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL dir[%0d]_fields: got %h want %h", i, obs, exp_v);
      end
      n_cmp++;
      if (obs.r !== dir_tab[i].r) begin
        n_fail++; $display("FAIL dir[%0d]_result: got %h want %h", i, obs.r, dir_tab[i].r);
      end
      n_cmp++;
      if (lat != want_lat) begin
        n_fail++; $display("FAIL dir[%0d]_latency: got %0d want %0d", i, lat, want_lat);
      end
      n_cmp++;
      if (leak !== 1'b0) begin
        n_fail++; $display("FAIL dir[%0d]_busy_ready: in_ready rose before result", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t exp_a, exp_b;
    exp_a = model(4'b0010, 32'h00001000, 32'h00000234, 4'h3);
    exp_b = model(4'b0110, 32'h00000010, 32'h00000020, 4'hC);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; alu_op = 4'b0010;
    op1 = 32'h00001000; op2 = 32'h00000234; in_tag = 4'h3;
    @(posedge clk);
    #1 alu_op = 4'b0110; op1 = 32'h00000010; op2 = 32'h00000020; in_tag = 4'hC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, observed()} !== {1'b1, exp_a}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", k, out_valid, observed(), exp_a);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready_low[%0d]: got %b want 0", k, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_release: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, observed()} !== {1'b1, exp_b}) begin
      n_fail++; $display("FAIL bp_second: got %b/%h want 1/%h", out_valid, observed(), exp_b);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'h00000001;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    exp_t sb[$];
    exp_t held_val, want;
    bit held = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op    = 4'($urandom);
      op1       = pick_operand();
      op2       = pick_operand();
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        n_cmp++;
        if ({out_valid, observed()} !== {1'b1, held_val}) begin
          n_fail++; $display("FAIL rnd_stable@%0d: got %b/%h want 1/%h", cyc, out_valid, observed(), held_val);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious@%0d: result %h with nothing outstanding", cyc, observed());
        end else begin
          want = sb.pop_front();
          if (observed() !== want) begin
            n_fail++; $display("FAIL rnd_result@%0d: got %h want %h", cyc, observed(), want);
          end
        end
      end
      held     = out_valid && !out_ready;
      held_val = observed();
      if (in_valid && in_ready) sb.push_back(model(alu_op, op1, op2, in_tag));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      if (out_valid) begin
        want = sb.pop_front();
        n_cmp++;
        if (observed() !== want) begin
          n_fail++; $display("FAIL rnd_drain: got %h want %h", observed(), want);
        end
      end
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rnd_outstanding: got %0d results missing want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_op();
    bit stale = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_op = MUL_EN ? 4'b0011 : 4'b0010;
    op1 = 32'h00010003; op2 = 32'h00000007; in_tag = 4'h9; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, observed()} !== '0) begin
      n_fail++; $display("FAIL rst_mid_clear: got %b/%h want 0/0", out_valid, observed());
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_release_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_stale: out_valid rose after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
